regfile_wport_arbiter: RTL and testbench

Round-robin arbiter sharing the single register-file write port among four write-back requesters: ALU result, load data, link address, and multiply/divide unit. Each cycle it selects at most one requester and drives the 2-bit select of the 4:1 5-bit destination-address mux and its companion data mux. It also presents a registered write enable, address and data to the register file. It sits between the write-back sources and the register file in the processor datapath.

---
 rtl/regfile_wport_arbiter.sv | 93 +++++++++
 tb/tb_regfile_wport_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter for the shared register-file write port.
// Grants one of four write-back requesters per cycle and registers the selected write.
module regfile_wport_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [3:0]              ReqValid,
  input  logic [4*ADDR_WIDTH-1:0] ReqAddr,
  input  logic [4*DATA_WIDTH-1:0] ReqData,
  input  logic                    Stall,
  output logic [3:0]              ReqReady,
  output logic [1:0]              MuxSel,
  output logic                    RegWrite,
  output logic [ADDR_WIDTH-1:0]   WriteAddr,
  output logic [DATA_WIDTH-1:0]   WriteData
);

  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            mux_sel_q, mux_sel_d;
  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

  logic                  grant_vld;
  logic [1:0]            grant_idx;
  logic [1:0]            scan_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Scan from the farthest candidate back to ptr so the closest valid one wins.
  // Only ReqValid, Stall, Rst and ptr feed the grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    scan_idx  = ptr_q;
    if (!Rst && !Stall) begin
      for (int k = 3; k >= 0; k--) begin
        scan_idx = ptr_q + 2'(k);
        if (ReqValid[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    ReqReady = 4'b0000;
    if (grant_vld) ReqReady = 4'b0001 << grant_idx;
  end

  always_comb begin
    sel_addr     = ReqAddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_data     = ReqData[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    ptr_d        = ptr_q;
    mux_sel_d    = mux_sel_q;
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (grant_vld) begin
      ptr_d        = grant_idx + 2'd1;
      mux_sel_d    = grant_idx;
      write_addr_d = sel_addr;
      write_data_d = sel_data;
      // $zero is accepted but never written.
      reg_write_d  = (sel_addr != '0);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr_q        <= 2'd0;
      mux_sel_q    <= 2'd0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      mux_sel_q    <= mux_sel_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign MuxSel    = mux_sel_q;
  assign RegWrite  = reg_write_q;
  assign WriteAddr = write_addr_q;
  assign WriteData = write_data_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Randomized bench for regfile_wport_arbiter against a per-requester pending-write model.
module tb_regfile_wport_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [3:0]    ReqValid;
  logic [4*AW-1:0] ReqAddr;
  logic [4*DW-1:0] ReqData;
  logic          Stall;
  logic [3:0]    ReqReady;
  logic [1:0]    MuxSel;
  logic          RegWrite;
  logic [AW-1:0] WriteAddr;
  logic [DW-1:0] WriteData;

  regfile_wport_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .Stall(Stall), .ReqReady(ReqReady), .MuxSel(MuxSel), .RegWrite(RegWrite),
    .WriteAddr(WriteAddr), .WriteData(WriteData)
  );

  always #5 Clk = ~Clk;

  // Requester-side view: which writes are outstanding and their contents.
  bit          pend[4];
  int unsigned pend_addr[4];
  int unsigned pend_data[4];

  // Reference state.
  int          m_ptr;
  int          m_sel;
  int          m_we;
  int unsigned m_addr;
  int unsigned m_data;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge: drive inputs, check the grant, advance one edge, check registers.
  task automatic step(input bit r, input bit s);
    int g;
    Rst   = r;
    Stall = s;
    for (int i = 0; i < 4; i++) begin
      ReqValid[i] = pend[i];
      ReqAddr[i*AW +: AW] = AW'(pend_addr[i]);
      ReqData[i*DW +: DW] = pend_data[i];
    end
    #1;
    g = -1;
    if (!r && !s)
      for (int k = 3; k >= 0; k--)
        if (pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    check_val("ReqReady", {28'd0, ReqReady}, (g < 0) ? 32'd0 : (32'd1 << g));
    @(posedge Clk);
    if (r) begin
      m_ptr = 0; m_sel = 0; m_we = 0; m_addr = 0; m_data = 0;
    end else if (g >= 0) begin
      m_sel  = g;
      m_addr = pend_addr[g];
      m_data = pend_data[g];
      m_we   = (pend_addr[g] != 0) ? 1 : 0;
      m_ptr  = (g + 1) % 4;
      pend[g] = 0;
    end else begin
      m_we = 0;
    end
    @(negedge Clk);
    check_val("RegWrite",  {31'd0, RegWrite},  m_we);
    check_val("MuxSel",    {30'd0, MuxSel},    m_sel);
    check_val("WriteAddr", {27'd0, WriteAddr}, m_addr);
    check_val("WriteData", WriteData,          m_data);
  endtask

  task automatic set_req(input int i, input int unsigned a, input int unsigned d);
    pend[i] = 1; pend_addr[i] = a; pend_data[i] = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) pend[i] = 0;
  endtask

  initial begin
    Rst = 1'b1; Stall = 1'b0; ReqValid = '0; ReqAddr = '0; ReqData = '0;
    m_ptr = 0; m_sel = 0; m_we = 0; m_addr = 0; m_data = 0;
    for (int i = 0; i < 4; i++) begin pend[i] = 0; pend_addr[i] = 0; pend_data[i] = 0; end
    @(negedge Clk);

    // Reset held with all requesters valid.
    for (int i = 0; i < 4; i++) set_req(i, i + 1, 32'h1000_0000 + i);
    step(1, 0);
    step(1, 0);

    // Round-robin with all requesters continuously valid.
    for (int c = 0; c < 8; c++) begin
      step(0, 0);
      for (int i = 0; i < 4; i++) if (!pend[i]) set_req(i, 8 + 4 * c + i, $urandom);
    end

    // Single requester to r31.
    clear_all();
    set_req(2, 31, 32'h0040_0010);
    step(0, 0);
    step(0, 0);

    // $zero request.
    set_req(1, 0, 32'hDEAD_BEEF);
    step(0, 0);

    // Stall holds the pointer.
    set_req(0, 3, 32'hA0A0_0000);
    set_req(1, 4, 32'hB1B1_0001);
    step(0, 1); step(0, 1); step(0, 1);
    step(0, 0);
    step(0, 0);

    // Reset the cycle after a grant to requester 3.
    clear_all();
    set_req(3, 17, 32'h3333_3333);
    step(0, 0);
    set_req(3, 18, 32'h3434_3434);
    step(1, 0);
    step(0, 0);

    // Random traffic; pending requests stay stable until transferred.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if (!pend[i] && ($urandom_range(1, 0) == 1))
          set_req(i, ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(31, 1), $urandom);
      step(($urandom_range(39, 0) == 0), ($urandom_range(4, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
